// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//
// Issue stage for the R-type shift instructions (SLL/SRL/SRA and the
// variable forms SLLV/SRLV/SRAV). It decodes one instruction at a time and
// loads the operand registers that feed an external barrel shifter. On the
// cycle after that, it captures the shifter's combinational result and then
// holds it until the consumer takes it. An unsupported funct skips the
// shifter and delivers a zero result with the illegal flag set.
//
// Ports
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   in_valid   instruction operands present
//   in_ready   stage can accept an instruction (IDLE only)
//   funct      R-type function field
//   shamt      immediate shift amount
//   rs         register value; rs[4:0] is the variable shift amount
//   rt         value to be shifted
//   sh_d       registered operand to the barrel shifter
//   sh_sa      registered shift amount to the barrel shifter
//   sh_right   registered direction to the shifter (1 = right)
//   sh_arith   registered arithmetic select to the shifter
//   sh_in      combinational result returned by the barrel shifter
//   out_valid  result available (DONE only)
//   out_ready  consumer accepts the result
//   result     registered shift result
//   illegal    held result came from an unsupported funct
//   op_count   count of legal instructions accepted (wraps silently)

module shift_issue_stage (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] sh_d,
    output logic [4:0]  sh_sa,
    output logic        sh_right,
    output logic        sh_arith,
    input  logic [31:0] sh_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        illegal,
    output logic [15:0] op_count
);

    // One-hot encoding, so that in_ready and out_valid are plain flop bits.
    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StShift = 3'b010,
        StDone  = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] sh_d_q, sh_d_d;
    logic [4:0]  sh_sa_q, sh_sa_d;
    logic        sh_right_q, sh_right_d;
    logic        sh_arith_q, sh_arith_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
    logic [15:0] op_count_q, op_count_d;

    logic        dec_legal;
    logic        dec_right;
    logic        dec_arith;
    logic        dec_var;
    logic [4:0]  dec_sa;
    logic        accept;

    // Only rs[4:0] is a shift amount; the upper register bits are unused.
    logic        unused_rs_hi;
    assign unused_rs_hi = ^rs[31:5];

    // funct decode
    always_comb begin
        dec_legal = 1'b1;
        dec_right = 1'b0;
        dec_arith = 1'b0;
        dec_var   = 1'b0;
        case (funct)
            6'b000000: ;                                              // SLL
            6'b000010: dec_right = 1'b1;                              // SRL
            6'b000011: begin dec_right = 1'b1; dec_arith = 1'b1; end  // SRA
            6'b000100: dec_var = 1'b1;                                // SLLV
            6'b000110: begin dec_var = 1'b1; dec_right = 1'b1; end    // SRLV
            6'b000111: begin                                          // SRAV
                dec_var   = 1'b1;
                dec_right = 1'b1;
                dec_arith = 1'b1;
            end
            default:   dec_legal = 1'b0;
        endcase
        dec_sa = dec_var ? rs[4:0] : shamt;
    end

    assign accept = (state_q == StIdle) && in_valid;

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = dec_legal ? StShift : StDone;
            StShift: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: operands change only on an accept.
    always_comb begin
        sh_d_d     = sh_d_q;
        sh_sa_d    = sh_sa_q;
        sh_right_d = sh_right_q;
        sh_arith_d = sh_arith_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        op_count_d = op_count_q;
        if (accept) begin
            if (dec_legal) begin
                sh_d_d     = rt;
                sh_sa_d    = dec_sa;
                sh_right_d = dec_right;
                sh_arith_d = dec_arith;
                illegal_d  = 1'b0;
                op_count_d = op_count_q + 16'd1;
            end else begin
                // Shifter operands stay put so its output remains deterministic.
                illegal_d  = 1'b1;
                result_d   = 32'd0;
            end
        end else if (state_q == StShift) begin
            result_d = sh_in;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sh_d_q     <= 32'd0;
            sh_sa_q    <= 5'd0;
            sh_right_q <= 1'b0;
            sh_arith_q <= 1'b0;
            result_q   <= 32'd0;
            illegal_q  <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            sh_d_q     <= sh_d_d;
            sh_sa_q    <= sh_sa_d;
            sh_right_q <= sh_right_d;
            sh_arith_q <= sh_arith_d;
            result_q   <= result_d;
            illegal_q  <= illegal_d;
            op_count_q <= op_count_d;
        end
    end

    // Outputs: every one is a flop bit or flop word, no input feeds through.
    always_comb begin
        in_ready  = state_q[0];
        out_valid = state_q[2];
        sh_d      = sh_d_q;
        sh_sa     = sh_sa_q;
        sh_right  = sh_right_q;
        sh_arith  = sh_arith_q;
        result    = result_q;
        illegal   = illegal_q;
        op_count  = op_count_q;
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage. A transaction-level model
// predicts every output each cycle; directed scenarios pin literal values.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] sh_d;
    logic [4:0]  sh_sa;
    logic        sh_right;
    logic        sh_arith;
    logic [31:0] sh_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic [15:0] op_count;

    int tests = 0;
    int fails = 0;

    shift_issue_stage dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .shamt     (shamt),
        .rs        (rs),
        .rt        (rt),
        .sh_d      (sh_d),
        .sh_sa     (sh_sa),
        .sh_right  (sh_right),
        .sh_arith  (sh_arith),
        .sh_in     (sh_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_shift(logic [31:0] d, logic [4:0] sa, logic right,
                                            logic arith);
        if (!right) return d << sa;
        if (arith) return 32'($signed(d) >>> sa);
        return d >> sa;
    endfunction

    // Barrel shifter stand-in
    always_comb sh_in = f_shift(sh_d, sh_sa, sh_right, sh_arith);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // {legal, right, arith, variable}
    function automatic logic [3:0] f_decode(logic [5:0] f);
        case (f)
            6'd0:    return 4'b1000;
            6'd2:    return 4'b1100;
            6'd3:    return 4'b1110;
            6'd4:    return 4'b1001;
            6'd6:    return 4'b1101;
            6'd7:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    logic [3:0]  dec;
    always_comb dec = f_decode(funct);

    // m_phase: 0 waiting for an instruction, 1 shifter busy, 2 result held
    int          m_phase;
    logic [31:0] m_d, m_result;
    logic [4:0]  m_sa;
    logic        m_right, m_arith, m_illegal;
    logic [15:0] m_count;
    logic        m_preload_en = 1'b0;
    logic [15:0] m_preload_val = 16'd0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_phase   <= 0;
            m_d       <= '0;
            m_sa      <= '0;
            m_right   <= 1'b0;
            m_arith   <= 1'b0;
            m_result  <= '0;
            m_illegal <= 1'b0;
            m_count   <= '0;
        end else begin
            if (m_preload_en) m_count <= m_preload_val;
            if (m_phase == 0) begin
                if (in_valid) begin
                    if (dec[3]) begin
                        m_d       <= rt;
                        m_sa      <= dec[0] ? rs[4:0] : shamt;
                        m_right   <= dec[2];
                        m_arith   <= dec[1];
                        m_illegal <= 1'b0;
                        m_count   <= m_count + 16'd1;
                        m_phase   <= 1;
                    end else begin
                        m_illegal <= 1'b1;
                        m_result  <= '0;
                        m_phase   <= 2;
                    end
                end
            end else if (m_phase == 1) begin
                m_result <= f_shift(m_d, m_sa, m_right, m_arith);
                m_phase  <= 2;
            end else if (out_ready) begin
                m_phase <= 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("sh_d",      sh_d,           m_d);
            chk("sh_sa",     32'(sh_sa),     32'(m_sa));
            chk("sh_right",  32'(sh_right),  32'(m_right));
            chk("sh_arith",  32'(sh_arith),  32'(m_arith));
            chk("result",    result,         m_result);
            chk("illegal",   32'(illegal),   32'(m_illegal));
            chk("op_count",  32'(op_count),  32'(m_count));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at/after a negedge with the stage idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        funct    = f;
        shamt    = sa;
        rs       = a;
        rt       = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
        chk("wait_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_tab [6];
        legal_tab = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        clrn = 1'b0; in_valid = 1'b0; funct = '0; shamt = '0; rs = '0; rt = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst sh_d",      sh_d,           32'd0);
        chk("rst sh_sa",     32'(sh_sa),     32'd0);
        chk("rst result",    result,         32'd0);
        chk("rst illegal",   32'(illegal),   32'd0);
        chk("rst op_count",  32'(op_count),  32'd0);
        cmp_en = 1'b1;
        clrn   = 1'b1;

        // SRA, accepted on the first edge after reset release
        issue(6'b000011, 5'd4, 32'h0, 32'h8000_0010);
        chk("sra sh_right",  32'(sh_right),  32'd1);
        chk("sra sh_arith",  32'(sh_arith),  32'd1);
        chk("sra sh_sa",     32'(sh_sa),     32'd4);
        chk("sra early ov",  32'(out_valid), 32'd0);
        @(negedge clk);
        chk("sra out_valid", 32'(out_valid), 32'd1);
        chk("sra result",    result,         32'hF800_0001);
        chk("sra op_count",  32'(op_count),  32'd1);
        wait_idle();

        // SLLV
        issue(6'b000100, 5'd17, 32'h0000_0023, 32'h0000_0001);
        chk("sllv sh_sa",    32'(sh_sa),     32'd3);
        chk("sllv sh_right", 32'(sh_right),  32'd0);
        @(negedge clk);
        chk("sllv result",   result,         32'h0000_0008);
        wait_idle();

        // Illegal funct: one-cycle latency, operands untouched
        issue(6'b100000, 5'd7, 32'h1F, 32'hDEAD_BEEF);
        chk("ill out_valid", 32'(out_valid), 32'd1);
        chk("ill illegal",   32'(illegal),   32'd1);
        chk("ill result",    result,         32'd0);
        chk("ill op_count",  32'(op_count),  32'd2);
        chk("ill sh_d",      sh_d,           32'h0000_0001);
        wait_idle();

        // Back-pressure: result held, second request ignored until IDLE
        out_ready = 1'b0;
        issue(6'b000010, 5'd8, 32'h0, 32'hF000_0000);
        @(negedge clk);
        chk("bp result", result, 32'h00F0_0000);
        in_valid = 1'b1; funct = 6'b000000; shamt = 5'd1; rt = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp hold result", result,         32'h00F0_0000);
            chk("bp in_ready",    32'(in_ready),  32'd0);
            chk("bp op_count",    32'(op_count),  32'd3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp 2nd sh_d",     sh_d,          32'd5);
        chk("bp 2nd op_count", 32'(op_count), 32'd4);
        wait_idle();
        chk("bp 2nd result", result, 32'h0000_000A);

        // Reset during SHIFT aborts the operation
        issue(6'b000010, 5'd1, 32'h0, 32'h0000_0100);
        #2 clrn = 1'b0;
        #1;
        chk("rmid out_valid", 32'(out_valid), 32'd0);
        chk("rmid result",    result,         32'd0);
        chk("rmid in_ready",  32'(in_ready),  32'd1);
        chk("rmid op_count",  32'(op_count),  32'd0);
        @(negedge clk);
        clrn = 1'b1;

        // Counter wrap: preload near the top, then three SRLs
        @(negedge clk);
        #1;
        force dut.op_count_q = 16'hFFFD;
        m_preload_val = 16'hFFFD;
        m_preload_en  = 1'b1;
        @(posedge clk);
        #1 m_preload_en = 1'b0;
        @(negedge clk);
        #1 release dut.op_count_q;
        for (int i = 0; i < 3; i++) begin
            issue(6'b000010, 5'(i), 32'h0, $urandom);
            wait_idle();
        end
        chk("wrap op_count", 32'(op_count), 32'd0);

        // Randomized traffic with back-pressure and occasional resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!clrn) clrn = 1'b1;
            in_valid  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) begin
                funct = 6'($urandom);
            end else begin
                int k;
                k = int'($urandom_range(0, 5));
                funct = legal_tab[k];
            end
            shamt     = 5'($urandom);
            rs        = $urandom;
            rt        = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) #2 clrn = 1'b0;
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
